// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first, computed as
// a + ~b + 1 through a single full-adder slice with a registered carry.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt;
  logic [WIDTH-1:0] r_diff, w_diff_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_a_msb, w_a_msb_nxt;
  logic             r_b_msb, w_b_msb_nxt;
  logic             r_borrow, w_borrow_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic             w_b_inv;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  // Single adder slice working on the current LSBs of the operand shifters
  assign w_b_inv = ~r_b[0];
  assign w_sum   = fa_sum(r_a[0], w_b_inv, r_carry);
  assign w_cout  = fa_carry(r_a[0], w_b_inv, r_carry);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_sh_nxt     = r_sh;
    w_diff_nxt   = r_diff;
    w_cnt_nxt    = r_cnt;
    w_carry_nxt  = r_carry;
    w_a_msb_nxt  = r_a_msb;
    w_b_msb_nxt  = r_b_msb;
    w_borrow_nxt = r_borrow;
    w_ovf_nxt    = r_ovf;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_sh_nxt    = '0;
          w_carry_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_a_msb_nxt = a[WIDTH-1];
          w_b_msb_nxt = b[WIDTH-1];
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_a_nxt     = r_a >> 1;
        w_b_nxt     = r_b >> 1;
        w_carry_nxt = w_cout;
        w_sh_nxt    = {w_sum, r_sh[WIDTH-1:1]};
        w_cnt_nxt   = r_cnt + CW'(1);
        // Result registers only update on the final bit, so diff/flags stay stable during RUN
        if (w_last) begin
          w_diff_nxt   = {w_sum, r_sh[WIDTH-1:1]};
          w_borrow_nxt = ~w_cout;
          w_ovf_nxt    = (r_a_msb != r_b_msb) && (w_sum != r_a_msb);
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_sh     <= w_sh_nxt;
      r_diff   <= w_diff_nxt;
      r_cnt    <= w_cnt_nxt;
      r_carry  <= w_carry_nxt;
      r_a_msb  <= w_a_msb_nxt;
      r_b_msb  <= w_b_msb_nxt;
      r_borrow <= w_borrow_nxt;
      r_ovf    <= w_ovf_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t mon_e;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no pulse (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("diff", 32'(diff), 32'(mon_e.d));
          chk("borrow_out", 32'(borrow_out), 32'(mon_e.bo));
          chk("overflow", 32'(overflow), 32'(mon_e.ov));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && done === 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%b done=%b want idle", busy, done);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] ed, input logic ebo, input logic eov);
    exp_t t;
    t.d  = ed;
    t.bo = ebo;
    t.ov = eov;
    sb.push_back(t);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ed, input logic ebo, input logic eov);
    wait_idle();
    start = 1'b1;
    a = ia;
    b = ib;
    push_exp(ed, ebo, eov);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] la, lb, ld;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrow_out), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // 7-3 with cycle-accurate busy/done latency
    issue(4'd7, 4'd3, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("lat_busy", 32'(busy), 1);
      chk("lat_done", 32'(done), 0);
    end
    @(negedge clk);
    chk("lat_busy_end", 32'(busy), 0);
    chk("lat_done_pulse", 32'(done), 1);
    @(negedge clk);
    chk("lat_done_clear", 32'(done), 0);

    issue(4'd3, 4'd7, 4'hC, 1'b1, 1'b0);
    issue(4'd0, 4'd0, 4'h0, 1'b0, 1'b0);
    issue(4'd8, 4'd1, 4'h7, 1'b0, 1'b1);
    issue(4'd7, 4'd8, 4'hF, 1'b1, 1'b1);
    drain();

    // Start held high; operands change during RUN
    wait_idle();
    start = 1'b1;
    a = 4'd9;
    b = 4'd4;
    push_exp(4'h5, 1'b0, 1'b1);
    push_exp(4'hC, 1'b1, 1'b0);
    @(posedge clk);
    #1 a = 4'd15; b = 4'd15;
    repeat (2) @(posedge clk);
    #1 a = 4'd2; b = 4'd6;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    drain();
    chk("hold_queue", 32'(sb.size()), 0);
    if (done_cyc.size() >= 2)
      chk("b2b_gap", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), W + 2);
    else
      chk("b2b_pulses", 32'(done_cyc.size()), 2);

    // Reset two cycles into an operation aborts it
    wait_idle();
    start = 1'b1;
    a = 4'd5;
    b = 4'd1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_diff", 32'(diff), 0);
    chk("abort_borrow", 32'(borrow_out), 0);
    chk("abort_ovf", 32'(overflow), 0);
    repeat (8) @(negedge clk);
    issue(4'd5, 4'd2, 4'h3, 1'b0, 1'b0);

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        la = W'(i);
        lb = W'(j);
        ld = la - lb;
        issue(la, lb, ld, (i < j), (la[W-1] != lb[W-1]) && (ld[W-1] != la[W-1]));
      end
    end
    drain();
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Bit-serial unsigned/two's-complement subtractor: computes diff = a - b, LSB first, one bit per clock. It uses a single full-adder slice with a registered carry (a + ~b + 1). It is the inverse-operation companion to the combinational full adder and is used as a small multi-cycle datapath unit. Operands are loaded on a start handshake, and the result is reported with a one-cycle done pulse.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when result is valid
diff  output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start
borrow_out  output  1  1 when a < b unsigned (inverse of final carry)
overflow  output  1  signed overflow of a - b

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
- Reset: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0, internal shift regs/count/carry=0.
- Reset has priority over everything, including mid-operation: the next edge with reset=1 aborts and returns to IDLE with the reset values above.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - capture a and b into shift registers;
  - carry<=1; count<=0;
  - latch sign bits a[WIDTH-1], b[WIDTH-1];
  - go to RUN; busy<=1.
  - diff, borrow_out and overflow keep their old values until DONE.
- RUN: each edge processes one bit:
  - s = A0 ^ ~B0 ^ carry; carry <= majority(A0, ~B0, carry);
  - shift s into diff from the MSB side; shift A and B right; count++.
  - After the WIDTH-th RUN edge: state<=DONE, busy<=0, done<=1.
  - On that same edge, borrow_out <= ~carry_next and overflow <= (a_msb != b_msb) && (diff_msb_next != a_msb).
- DONE: lasts exactly one cycle with done=1; the next edge goes to IDLE with done<=0.
- start is ignored in RUN and DONE. A new request must be presented in IDLE.
- Latency: start is sampled at edge E0, busy is high from E0 to E_WIDTH, and done is high between E_WIDTH and E_WIDTH+1. Back-to-back requests can therefore be accepted every WIDTH+2 cycles.
- Changes to a and b after the accepting edge have no effect on the operation in progress.
- Width rules: all arithmetic is modulo 2^WIDTH. The bit counter is ceil(log2(WIDTH+1)) bits wide.

Test Plan:
- WIDTH=4, a=7, b=3, pulse start -> busy high for 4 cycles; done pulse on the 4th edge after start; diff=4, borrow_out=0, overflow=0.
- a=3, b=7 -> diff=4'hC, borrow_out=1, overflow=0; 0-0 -> diff=0, borrow_out=0, overflow=0.
- a=8, b=1 -> diff=7, borrow_out=0, overflow=1. Then a=7, b=8 -> diff=4'hF, borrow_out=1, overflow=1.
- Hold start=1 continuously with changing a/b during RUN -> only the operands present at the accepting edge are used. The next accept happens on the first IDLE edge, with exactly one done pulse per operation.
- Assert reset for one edge two cycles after start -> busy=0, done=0, diff=0 next cycle, and no done pulse follows. A new start then completes correctly (e.g. 5-2=3).
- Exhaustive loop over all 256 (a, b) pairs at WIDTH=4, self-checked against (a-b)&4'hF, a<b, and signed overflow; 0 mismatches required.
